timing_control_unit: RTL and testbench
======================================

TIMING_CONTROL_UNIT -- requirements
Module: timing_control_unit

Interface
REQ-001 SHALL have parameter EXEC_MAX, default 4'd12: last T-state an execute phase may reach before forced abort.
REQ-002 SHALL have port CLK  input  1  system clock, rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port COUNT  input  4  sequence-counter value.
REQ-005 SHALL have port IR  input  16  instruction register contents.
REQ-006 SHALL have port EXEC_DONE  input  1  execute unit finished current instruction.
REQ-007 SHALL have port START  input  1  sets run flag when halted.
REQ-008 SHALL have port T  output  16  one-hot timing decode of COUNT.
REQ-009 SHALL have port SC_CLR, SC_INC  output  1 each  sequence-counter controls.
REQ-010 SHALL have port LD_AR, LD_IR, INR_PC, MEM_RD  output  1 each  fetch/decode strobes.
REQ-011 SHALL have port BUS_SEL  output  3  common-bus source (0 none, 2 PC, 5 AR, 7 MEM).
REQ-012 SHALL have port D  output  8  registered one-hot opcode decode; I  output  1  registered indirect bit.
REQ-013 SHALL have port S  output  1  run flag; INSTR_DONE  output  1  one-cycle completion pulse; ABORT  output  1  sticky watchdog flag.

Function
REQ-014 T SHALL be combinational: T[k]=1 iff COUNT==k; exactly one bit high.
REQ-015 All strobes SHALL be combinational from T, S, D, I, registered state; all zero when S=0.
REQ-016 Phases SHALL be: FETCH (T0,T1), DECODE (T2), INDIRECT (T3), EXEC (T4..EXEC_MAX), plus SYNC after reset.
REQ-017 T0 with S=1: BUS_SEL=2, LD_AR=1, SC_INC=1.
REQ-018 T1 with S=1: BUS_SEL=7, MEM_RD=1, LD_IR=1, INR_PC=1, SC_INC=1.
REQ-019 T2 with S=1: BUS_SEL=5? no -- BUS_SEL=7 off; BUS_SEL=0, LD_AR=1 (AR<-IR[11:0] via dedicated path), SC_INC=1; at the rising edge D<=onehot(IR[14:12]) and I<=IR[15].
REQ-020 T3, D[7]=0, I=1: BUS_SEL=7, MEM_RD=1, LD_AR=1, SC_INC=1; if I=0: SC_INC=1 only.
REQ-021 T3, D[7]=1 (register reference): if IR[0]=1 (HLT) S SHALL clear at that edge; SC_CLR=1 and INSTR_DONE=1 regardless of IR bits.
REQ-022 EXEC (COUNT 4..EXEC_MAX): SC_INC=1 until EXEC_DONE=1; EXEC_DONE=1 SHALL give SC_CLR=1, SC_INC=0, INSTR_DONE=1 same cycle.
REQ-023 EXEC_DONE SHALL be ignored outside EXEC.
REQ-024 If COUNT==EXEC_MAX and EXEC_DONE=0: SC_CLR=1, ABORT set (sticky), S cleared.
REQ-025 COUNT>EXEC_MAX with SYNC flag set SHALL be treated as REQ-024 (illegal count).
REQ-026 SC_CLR and SC_INC SHALL never be high together; SC_CLR has priority.
REQ-027 When S=0: SC_CLR=1 every cycle (holds counter at 0); no other strobe.
REQ-028 START=1 with S=0 SHALL set S and clear ABORT at next edge; START ignored when S=1.
REQ-029 SYNC flag: cleared by reset; while clear, SC_CLR=1, no strobes, no ABORT; sets when COUNT==0 observed.
REQ-030 D and I SHALL change only at T2 edge with S=1.

Reset
REQ-031 reset SHALL asynchronously force S=1, SYNC=0, ABORT=0, D=8'h01, I=0.
REQ-032 During/after reset with COUNT=15 (counter's reset value): SC_CLR=1, all other strobes 0, INSTR_DONE=0, ABORT stays 0.
REQ-033 reset mid-instruction SHALL abandon it with no INSTR_DONE pulse.

Verification
REQ-034 Reset, COUNT=15 then 0 -> cycle 1 SC_CLR=1, ABORT=0; COUNT=0 sets SYNC, T=16'h0001, LD_AR=1, BUS_SEL=2.
REQ-035 IR=16'h9005 (I=1, ADD): COUNT 0..5, EXEC_DONE at T5 -> D=8'h02, I=1, T3 MEM_RD=1/LD_AR=1, T5 SC_CLR=1, INSTR_DONE one pulse.
REQ-036 IR=16'h7001 (HLT) -> T3 SC_CLR=1, S=0 next cycle, thereafter SC_CLR=1 only; START=1 -> S=1.
REQ-037 IR=16'h2010, EXEC_DONE never -> at COUNT=12 SC_CLR=1, ABORT=1, S=0; START clears ABORT.
REQ-038 EXEC_DONE=1 during T0..T3 -> no effect on SC_CLR/INSTR_DONE; assert SC_CLR&SC_INC never both high across all tests.

Source files
------------

// File: rtl/timing_control_unit.sv
// Timing and control sequencer for a basic accumulator machine: decodes the
// sequence counter into T-states and issues fetch/decode/execute strobes.
module timing_control_unit #(
  parameter logic [3:0] EXEC_MAX = 4'd12
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  COUNT,
  input  logic [15:0] IR,
  input  logic        EXEC_DONE,
  input  logic        START,
  output logic [15:0] T,
  output logic        SC_CLR,
  output logic        SC_INC,
  output logic        LD_AR,
  output logic        LD_IR,
  output logic        INR_PC,
  output logic        MEM_RD,
  output logic [2:0]  BUS_SEL,
  output logic [7:0]  D,
  output logic        I,
  output logic        S,
  output logic        INSTR_DONE,
  output logic        ABORT
);

  typedef enum logic [2:0] {
    PH_IDLE, PH_FETCH0, PH_FETCH1, PH_DECODE, PH_INDIRECT, PH_EXEC, PH_ILLEGAL
  } phase_e;

  phase_e     phase;
  logic       runFlag_q, runFlag_d;
  logic       sync_q, sync_d;
  logic       abort_q, abort_d;
  logic [7:0] opDecode_q, opDecode_d;
  logic       indirect_q, indirect_d;
  logic       unusedIr;

  assign unusedIr = ^IR[11:1];
  assign T        = 16'd1 << COUNT;
  assign D        = opDecode_q;
  assign I        = indirect_q;
  assign S        = runFlag_q;
  assign ABORT    = abort_q;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      runFlag_q  <= 1'b1;
      sync_q     <= 1'b0;
      abort_q    <= 1'b0;
      opDecode_q <= 8'h01;
      indirect_q <= 1'b0;
    end else begin
      runFlag_q  <= runFlag_d;
      sync_q     <= sync_d;
      abort_q    <= abort_d;
      opDecode_q <= opDecode_d;
      indirect_q <= indirect_d;
    end
  end

  // Halted or not yet aligned with the counter: everything collapses to IDLE.
  always_comb begin
    phase = PH_IDLE;
    if (runFlag_q && sync_q) begin
      if (COUNT > EXEC_MAX) begin
        phase = PH_ILLEGAL;
      end else begin
        case (COUNT)
          4'd0:    phase = PH_FETCH0;
          4'd1:    phase = PH_FETCH1;
          4'd2:    phase = PH_DECODE;
          4'd3:    phase = PH_INDIRECT;
          default: phase = PH_EXEC;
        endcase
      end
    end
  end

  always_comb begin
    SC_CLR     = 1'b0;
    SC_INC     = 1'b0;
    LD_AR      = 1'b0;
    LD_IR      = 1'b0;
    INR_PC     = 1'b0;
    MEM_RD     = 1'b0;
    BUS_SEL    = 3'd0;
    INSTR_DONE = 1'b0;
    runFlag_d  = runFlag_q;
    sync_d     = sync_q | (COUNT == 4'd0);
    abort_d    = abort_q;
    opDecode_d = opDecode_q;
    indirect_d = indirect_q;
    case (phase)
      PH_IDLE: SC_CLR = 1'b1;
      PH_FETCH0: begin
        BUS_SEL = 3'd2;
        LD_AR   = 1'b1;
        SC_INC  = 1'b1;
      end
      PH_FETCH1: begin
        BUS_SEL = 3'd7;
        MEM_RD  = 1'b1;
        LD_IR   = 1'b1;
        INR_PC  = 1'b1;
        SC_INC  = 1'b1;
      end
      PH_DECODE: begin
        LD_AR      = 1'b1;
        SC_INC     = 1'b1;
        opDecode_d = 8'd1 << IR[14:12];
        indirect_d = IR[15];
      end
      // Register-reference instructions finish here; IR[0] is the halt bit.
      PH_INDIRECT: begin
        if (opDecode_q[7]) begin
          SC_CLR     = 1'b1;
          INSTR_DONE = 1'b1;
          if (IR[0]) runFlag_d = 1'b0;
        end else if (indirect_q) begin
          BUS_SEL = 3'd7;
          MEM_RD  = 1'b1;
          LD_AR   = 1'b1;
          SC_INC  = 1'b1;
        end else begin
          SC_INC = 1'b1;
        end
      end
      PH_EXEC: begin
        if (EXEC_DONE) begin
          SC_CLR     = 1'b1;
          INSTR_DONE = 1'b1;
        end else if (COUNT == EXEC_MAX) begin
          SC_CLR    = 1'b1;
          abort_d   = 1'b1;
          runFlag_d = 1'b0;
        end else begin
          SC_INC = 1'b1;
        end
      end
      PH_ILLEGAL: begin
        SC_CLR    = 1'b1;
        abort_d   = 1'b1;
        runFlag_d = 1'b0;
      end
      default: SC_CLR = 1'b1;
    endcase
    if (!runFlag_q && START) begin
      runFlag_d = 1'b1;
      abort_d   = 1'b0;
    end
  end

endmodule

// File: tb/tb_timing_control_unit.sv
// Self-checking bench for timing_control_unit: directed scenarios followed by
// randomized traffic against a phase-level reference model.
module tb_timing_control_unit;

  localparam logic [3:0] EXEC_MAX = 4'd12;

  localparam logic [9:0] E_CLR  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [9:0] E_T0   = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
  localparam logic [9:0] E_T1   = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'd7, 1'b0};
  localparam logic [9:0] E_T2   = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [9:0] E_T3I  = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0};
  localparam logic [9:0] E_INC  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
  localparam logic [9:0] E_DONE = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  COUNT = 4'd15;
  logic [15:0] IR = 16'h0000;
  logic        EXEC_DONE = 1'b0;
  logic        START = 1'b0;
  logic [15:0] T;
  logic        SC_CLR, SC_INC, LD_AR, LD_IR, INR_PC, MEM_RD;
  logic [2:0]  BUS_SEL;
  logic [7:0]  D;
  logic        I, S, INSTR_DONE, ABORT;
  logic [9:0]  obs;
  int          total = 0;
  int          bad = 0;

  timing_control_unit #(.EXEC_MAX(EXEC_MAX)) dut (
    .CLK(CLK), .reset(reset), .COUNT(COUNT), .IR(IR), .EXEC_DONE(EXEC_DONE),
    .START(START), .T(T), .SC_CLR(SC_CLR), .SC_INC(SC_INC), .LD_AR(LD_AR),
    .LD_IR(LD_IR), .INR_PC(INR_PC), .MEM_RD(MEM_RD), .BUS_SEL(BUS_SEL),
    .D(D), .I(I), .S(S), .INSTR_DONE(INSTR_DONE), .ABORT(ABORT)
  );

  assign obs = {SC_CLR, SC_INC, LD_AR, LD_IR, INR_PC, MEM_RD, BUS_SEL, INSTR_DONE};

  always #5 CLK = ~CLK;

  // Inputs change just after a falling edge; outputs settle 2 time units later.
  task set_inputs(input logic [3:0] c, input logic [15:0] ir, input logic xd, input logic st);
    COUNT = c;
    IR = ir;
    EXEC_DONE = xd;
    START = st;
    #2;
  endtask

  task tick;
    @(negedge CLK);
  endtask

  task sync_up;
    reset = 1'b1;
    set_inputs(4'd15, 16'h0000, 1'b0, 1'b0);
    @(negedge CLK);
    reset = 1'b0;
    set_inputs(4'd15, 16'h0000, 1'b0, 1'b0);
    tick;
    set_inputs(4'd0, 16'h0000, 1'b0, 1'b0);
    tick;
  endtask

  task test_reset;
    reset = 1'b1;
    set_inputs(4'd15, 16'h0000, 1'b0, 1'b0);
    @(posedge CLK);
    #1;
    total++; if (obs !== E_CLR) begin bad++; $display("[TB] FAIL rst_strobes got=%h want=%h", obs, E_CLR); end
    total++; if ({S, ABORT, D, I} !== {1'b1, 1'b0, 8'h01, 1'b0}) begin bad++; $display("[TB] FAIL rst_state got=%b want=%b", {S, ABORT, D, I}, {1'b1, 1'b0, 8'h01, 1'b0}); end
    total++; if (T !== 16'h8000) begin bad++; $display("[TB] FAIL rst_T got=%h want=8000", T); end
    @(negedge CLK);
    reset = 1'b0;
    set_inputs(4'd15, 16'h0000, 1'b0, 1'b0);
    total++; if ({obs, ABORT} !== {E_CLR, 1'b0}) begin bad++; $display("[TB] FAIL rst_c15 got=%h want=%h", {obs, ABORT}, {E_CLR, 1'b0}); end
    tick;
    set_inputs(4'd0, 16'h0000, 1'b0, 1'b0);
    total++; if ({obs, ABORT} !== {E_CLR, 1'b0}) begin bad++; $display("[TB] FAIL rst_sync_cycle got=%h want=%h", {obs, ABORT}, {E_CLR, 1'b0}); end
    tick;
    set_inputs(4'd0, 16'h0000, 1'b0, 1'b0);
    total++; if (obs !== E_T0) begin bad++; $display("[TB] FAIL rst_first_t0 got=%h want=%h", obs, E_T0); end
    total++; if (T !== 16'h0001) begin bad++; $display("[TB] FAIL rst_T0 got=%h want=0001", T); end
    tick;
  endtask

  task test_indirect_add;
    logic [9:0] want [6];
    want = '{E_T0, E_T1, E_T2, E_T3I, E_INC, E_DONE};
    sync_up;
    for (int c = 0; c < 6; c++) begin
      set_inputs(4'(c), 16'h9005, (c == 5), 1'b0);
      total++; if (obs !== want[c]) begin bad++; $display("[TB] FAIL add_t%0d got=%h want=%h", c, obs, want[c]); end
      if (c == 3) begin
        total++; if ({D, I} !== {8'h02, 1'b1}) begin bad++; $display("[TB] FAIL add_decode got=%h/%b want=02/1", D, I); end
      end
      tick;
    end
    set_inputs(4'd0, 16'h9005, 1'b0, 1'b0);
    total++; if (obs !== E_T0) begin bad++; $display("[TB] FAIL add_single_pulse got=%h want=%h", obs, E_T0); end
    tick;
  endtask

  task test_halt;
    sync_up;
    for (int c = 0; c < 3; c++) begin
      set_inputs(4'(c), 16'h7001, 1'b0, 1'b0);
      tick;
    end
    set_inputs(4'd3, 16'h7001, 1'b0, 1'b0);
    total++; if ({obs, S} !== {E_DONE, 1'b1}) begin bad++; $display("[TB] FAIL hlt_t3 got=%h want=%h", {obs, S}, {E_DONE, 1'b1}); end
    tick;
    set_inputs(4'd0, 16'h7001, 1'b0, 1'b0);
    total++; if ({obs, S, D} !== {E_CLR, 1'b0, 8'h80}) begin bad++; $display("[TB] FAIL hlt_stopped got=%h want=%h", {obs, S, D}, {E_CLR, 1'b0, 8'h80}); end
    tick;
    set_inputs(4'd0, 16'h7001, 1'b0, 1'b1);
    total++; if (obs !== E_CLR) begin bad++; $display("[TB] FAIL hlt_idle got=%h want=%h", obs, E_CLR); end
    tick;
    set_inputs(4'd0, 16'h7001, 1'b0, 1'b0);
    total++; if ({S, obs} !== {1'b1, E_T0}) begin bad++; $display("[TB] FAIL hlt_restart got=%h want=%h", {S, obs}, {1'b1, E_T0}); end
    tick;
  endtask

  task test_abort;
    sync_up;
    for (int c = 0; c <= int'(EXEC_MAX); c++) begin
      set_inputs(4'(c), 16'h2010, 1'b0, 1'b0);
      if (c >= 4) begin
        total++;
        if (obs !== ((c == int'(EXEC_MAX)) ? E_CLR : E_INC)) begin
          bad++; $display("[TB] FAIL abort_t%0d got=%h want=%h", c, obs, (c == int'(EXEC_MAX)) ? E_CLR : E_INC);
        end
      end
      tick;
    end
    set_inputs(4'd0, 16'h2010, 1'b0, 1'b0);
    total++; if ({ABORT, S, obs} !== {1'b1, 1'b0, E_CLR}) begin bad++; $display("[TB] FAIL abort_flag got=%h want=%h", {ABORT, S, obs}, {1'b1, 1'b0, E_CLR}); end
    tick;
    set_inputs(4'd0, 16'h2010, 1'b0, 1'b1);
    tick;
    set_inputs(4'd0, 16'h2010, 1'b0, 1'b0);
    total++; if ({ABORT, S} !== 2'b01) begin bad++; $display("[TB] FAIL abort_clear got=%b want=01", {ABORT, S}); end
    tick;
  endtask

  task test_illegal_count;
    sync_up;
    set_inputs(4'd14, 16'h0000, 1'b1, 1'b0);
    total++; if (obs !== E_CLR) begin bad++; $display("[TB] FAIL illegal_strobes got=%h want=%h", obs, E_CLR); end
    tick;
    set_inputs(4'd0, 16'h0000, 1'b0, 1'b0);
    total++; if ({ABORT, S} !== 2'b10) begin bad++; $display("[TB] FAIL illegal_flags got=%b want=10", {ABORT, S}); end
    tick;
  endtask

  task test_exec_done_ignored;
    logic [9:0] want [4];
    want = '{E_T0, E_T1, E_T2, E_INC};
    sync_up;
    for (int c = 0; c < 4; c++) begin
      set_inputs(4'(c), 16'h1000, 1'b1, 1'b0);
      total++; if (obs !== want[c]) begin bad++; $display("[TB] FAIL xdone_t%0d got=%h want=%h", c, obs, want[c]); end
      tick;
    end
  endtask

  task test_mid_reset;
    sync_up;
    for (int c = 0; c < 5; c++) begin
      set_inputs(4'(c), 16'h1000, 1'b0, 1'b0);
      tick;
    end
    set_inputs(4'd5, 16'h1000, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    total++; if ({obs, S} !== {E_CLR, 1'b1}) begin bad++; $display("[TB] FAIL midrst got=%h want=%h", {obs, S}, {E_CLR, 1'b1}); end
    @(negedge CLK);
    reset = 1'b0;
    set_inputs(4'd0, 16'h1000, 1'b0, 1'b0);
    total++; if (obs !== E_CLR) begin bad++; $display("[TB] FAIL midrst_resync got=%h want=%h", obs, E_CLR); end
    tick;
  endtask

  // Reference model tracks run/sync/abort flags, opcode number and counter.
  task test_random;
    logic       ms, msync, mabort, mi, active, xd, st, oldMs;
    logic [2:0] mop;
    logic [3:0] cnt;
    logic [15:0] ir;
    logic [9:0] exp;
    reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    ms = 1'b1; msync = 1'b0; mabort = 1'b0; mop = 3'd0; mi = 1'b0; cnt = 4'd15;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1'b1;
        #1;
        total++; if ({obs, S} !== {E_CLR, 1'b1}) begin bad++; $display("[TB] FAIL rnd_reset n=%0d got=%h want=%h", n, {obs, S}, {E_CLR, 1'b1}); end
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        ms = 1'b1; msync = 1'b0; mabort = 1'b0; mop = 3'd0; mi = 1'b0; cnt = 4'd15;
      end
      if ($urandom_range(0, 59) == 0) cnt = 4'($urandom_range(0, 15));
      ir = 16'($urandom);
      xd = (cnt >= 4) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) == 0);
      set_inputs(cnt, ir, xd, st);
      active = ms && msync;
      exp = E_CLR;
      if (active) begin
        if (cnt == 0) exp = E_T0;
        else if (cnt == 1) exp = E_T1;
        else if (cnt == 2) exp = E_T2;
        else if (cnt == 3) exp = (mop == 3'd7) ? E_DONE : (mi ? E_T3I : E_INC);
        else if (cnt <= EXEC_MAX && xd) exp = E_DONE;
        else if (cnt < EXEC_MAX) exp = E_INC;
        else exp = E_CLR;
      end
      total++; if (obs !== exp) begin bad++; $display("[TB] FAIL rnd_strobes n=%0d cnt=%0d got=%h want=%h", n, cnt, obs, exp); end
      total++;
      if ({T, D, I, S, ABORT} !== {16'd1 << cnt, 8'd1 << mop, mi, ms, mabort}) begin
        bad++; $display("[TB] FAIL rnd_state n=%0d got=%h want=%h", n, {T, D, I, S, ABORT}, {16'd1 << cnt, 8'd1 << mop, mi, ms, mabort});
      end
      total++; if ((SC_CLR & SC_INC) !== 1'b0) begin bad++; $display("[TB] FAIL rnd_clr_inc n=%0d got=1 want=0", n); end
      oldMs = ms;
      if (active) begin
        if (cnt == 2) begin mop = ir[14:12]; mi = ir[15]; end
        if (cnt == 3 && mop == 3'd7 && ir[0]) ms = 1'b0;
        if (cnt >= 4 && !(cnt <= EXEC_MAX && xd) && cnt >= EXEC_MAX) begin
          mabort = 1'b1; ms = 1'b0;
        end
      end
      if (!oldMs && st) begin ms = 1'b1; mabort = 1'b0; end
      msync = msync | (cnt == 0);
      if (exp[9]) cnt = 4'd0;
      else if (exp[8]) cnt = cnt + 4'd1;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_indirect_add;
    test_halt;
    test_abort;
    test_illegal_count;
    test_exec_done_ignored;
    test_mid_reset;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
